// File: rtl/fifo_rd_ctrl.sv
// rtl/fifo_rd_ctrl.sv - async FIFO read-side controller: write-pointer sync, EMPTY, registered output stage.
// Optional RD_LEVEL occupancy output enabled by defining FIFO_RD_LEVEL_EN.
module fifo_rd_ctrl #(
  parameter int PTR_WD  = 4,
  parameter int DATA_WD = 8,
  parameter int FIFO_DP = 8
) (
  input  logic               R_CLK,
  input  logic               R_RST,
  input  logic [PTR_WD-1:0]  wr_ptr_gray,
  input  logic [DATA_WD-1:0] MEM_RD_DATA,
  input  logic               RD_READY,
  output logic [PTR_WD-2:0]  rd_addr,
  output logic [PTR_WD-1:0]  rd_ptr_gray,
  output logic               EMPTY,
  output logic [DATA_WD-1:0] RD_DATA,
  output logic               RD_VALID
`ifdef FIFO_RD_LEVEL_EN
  ,
  output logic [PTR_WD-1:0]  RD_LEVEL
`endif
);

  localparam int ADDR_WD = $clog2(FIFO_DP);

  logic [PTR_WD-1:0] wq1;
  logic [PTR_WD-1:0] wq2;
  logic [PTR_WD-1:0] rd_bin;
  logic [PTR_WD-1:0] rd_bin_next;
  logic [PTR_WD-1:0] rd_gray_next;
  logic              pop;

  // A word moves from memory into the output register whenever the register is free or being drained.
  assign pop          = ~EMPTY & (~RD_VALID | RD_READY);
  assign rd_bin_next  = rd_bin + PTR_WD'(pop);
  assign rd_gray_next = rd_bin_next ^ (rd_bin_next >> 1);
  assign rd_addr      = rd_bin[ADDR_WD-1:0];

  always_ff @(posedge R_CLK or negedge R_RST) begin
    if (!R_RST) begin
      wq1 <= '0;
      wq2 <= '0;
    end else begin
      wq1 <= wr_ptr_gray;
      wq2 <= wq1;
    end
  end

  always_ff @(posedge R_CLK or negedge R_RST) begin
    if (!R_RST) begin
      rd_bin      <= '0;
      rd_ptr_gray <= '0;
      EMPTY       <= 1'b1;
    end else begin
      rd_bin      <= rd_bin_next;
      rd_ptr_gray <= rd_gray_next;
      EMPTY       <= (rd_gray_next == wq2);
    end
  end

  always_ff @(posedge R_CLK or negedge R_RST) begin
    if (!R_RST) begin
      RD_DATA  <= '0;
      RD_VALID <= 1'b0;
    end else if (pop) begin
      RD_DATA  <= MEM_RD_DATA;
      RD_VALID <= 1'b1;
    end else if (RD_VALID && RD_READY) begin
      RD_VALID <= 1'b0;
    end
  end

`ifdef FIFO_RD_LEVEL_EN
  function automatic logic [PTR_WD-1:0] gray2bin(input logic [PTR_WD-1:0] g);
    logic [PTR_WD-1:0] b;
    b[PTR_WD-1] = g[PTR_WD-1];
    for (int i = PTR_WD - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Occupancy of memory only; the word parked in RD_DATA is not counted.
  always_ff @(posedge R_CLK or negedge R_RST) begin
    if (!R_RST) begin
      RD_LEVEL <= '0;
    end else begin
      RD_LEVEL <= gray2bin(wq2) - rd_bin_next;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb/tb_fifo_rd_ctrl.sv - self-checking bench for fifo_rd_ctrl: vector table, corner sequences, random vs model.
module tb_fifo_rd_ctrl;

  logic       R_CLK = 1'b0;
  logic       R_RST = 1'b0;
  logic [3:0] wr_ptr_gray = 4'h0;
  logic [7:0] MEM_RD_DATA;
  logic       RD_READY = 1'b0;
  logic [2:0] rd_addr;
  logic [3:0] rd_ptr_gray;
  logic       EMPTY;
  logic [7:0] RD_DATA;
  logic       RD_VALID;
`ifdef FIFO_RD_LEVEL_EN
  logic [3:0] RD_LEVEL;
`endif

  logic [7:0] mem [8];
  assign MEM_RD_DATA = mem[rd_addr];

  fifo_rd_ctrl #(.PTR_WD(4), .DATA_WD(8), .FIFO_DP(8)) dut (
    .R_CLK      (R_CLK),
    .R_RST      (R_RST),
    .wr_ptr_gray(wr_ptr_gray),
    .MEM_RD_DATA(MEM_RD_DATA),
    .RD_READY   (RD_READY),
    .rd_addr    (rd_addr),
    .rd_ptr_gray(rd_ptr_gray),
    .EMPTY      (EMPTY),
    .RD_DATA    (RD_DATA),
    .RD_VALID   (RD_VALID)
`ifdef FIFO_RD_LEVEL_EN
    ,
    .RD_LEVEL   (RD_LEVEL)
`endif
  );

  always #5 R_CLK = ~R_CLK;

  int errors = 0;
  int checks = 0;

  // Reference model: counts of words written/read and a queue of words in flight.
  int         wp;
  int         mcnt;
  int         s1, s2;
  bit         m_empty, m_valid;
  logic [7:0] m_data;
  int         m_level;
  logic [7:0] q[$];

  typedef struct {
    bit         wr;
    logic [7:0] wd;
    bit         rdy;
    bit         e;
    bit         v;
    logic [7:0] d;
    logic [2:0] a;
    logic [3:0] g;
  } vec_t;
  vec_t tbl[16];

  function automatic logic [3:0] gray(input int b);
    logic [3:0] x;
    x = 4'(b);
    return x ^ (x >> 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    wp = 0; mcnt = 0; s1 = 0; s2 = 0;
    m_empty = 1'b1; m_valid = 1'b0; m_data = 8'h00; m_level = 0;
    q.delete();
    wr_ptr_gray = 4'h0;
  endtask

  function automatic int occupancy();
    return (wp - mcnt) & 15;
  endfunction

  task automatic run_cycle(input bit wr, input logic [7:0] wd, input bit rdy);
    bit pop;
    if (wr) begin
      mem[wp % 8] = wd;
      q.push_back(wd);
      wp = (wp + 1) % 16;
      wr_ptr_gray = gray(wp);
    end
    RD_READY = rdy;
    pop = !m_empty && (!m_valid || rdy);
    if (pop) begin
      m_data  = q.pop_front();
      m_valid = 1'b1;
      mcnt    = (mcnt + 1) % 16;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    m_empty = (((s2 - mcnt) & 15) == 0);
    m_level = (s2 - mcnt) & 15;
    s2 = s1;
    s1 = wp;
    @(posedge R_CLK);
    #1;
    check("model_empty", EMPTY, m_empty);
    check("model_valid", RD_VALID, m_valid);
    check("model_data", RD_DATA, m_data);
    check("model_addr", rd_addr, mcnt % 8);
    check("model_gray", rd_ptr_gray, gray(mcnt));
`ifdef FIFO_RD_LEVEL_EN
    check("model_level", RD_LEVEL, m_level);
`endif
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_empty"}, EMPTY, 1'b1);
    check({tag, "_valid"}, RD_VALID, 1'b0);
    check({tag, "_data"}, RD_DATA, 8'h00);
    check({tag, "_addr"}, rd_addr, 3'd0);
    check({tag, "_gray"}, rd_ptr_gray, 4'h0);
`ifdef FIFO_RD_LEVEL_EN
    check({tag, "_level"}, RD_LEVEL, 4'h0);
`endif
  endtask

  initial begin
    int got, nxt, gaps;
    bit primed, wr;

    foreach (mem[i]) mem[i] = 8'h00;
    model_reset();
    #12;
    check_reset_state("reset_init");
    R_RST = 1'b1;

    // Single word then back-pressured three-word burst.
    tbl[0]  = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 4'h0};
    tbl[1]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 4'h0};
    tbl[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 4'h0};
    tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA5, 3'd1, 4'h1};
    tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hA5, 3'd1, 4'h1};
    tbl[5]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 8'hA5, 3'd1, 4'h1};
    tbl[6]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 8'hA5, 3'd1, 4'h1};
    tbl[7]  = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 8'hA5, 3'd1, 4'h1};
    tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h11, 3'd2, 4'h3};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h11, 3'd2, 4'h3};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h11, 3'd2, 4'h3};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h11, 3'd2, 4'h3};
    tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h11, 3'd2, 4'h3};
    tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h22, 3'd3, 4'h2};
    tbl[14] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h33, 3'd4, 4'h6};
    tbl[15] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h33, 3'd4, 4'h6};
    for (int i = 0; i < 16; i++) begin
      run_cycle(tbl[i].wr, tbl[i].wd, tbl[i].rdy);
      check($sformatf("vec%0d_empty", i), EMPTY, tbl[i].e);
      check($sformatf("vec%0d_valid", i), RD_VALID, tbl[i].v);
      check($sformatf("vec%0d_data", i), RD_DATA, tbl[i].d);
      check($sformatf("vec%0d_addr", i), rd_addr, tbl[i].a);
      check($sformatf("vec%0d_gray", i), rd_ptr_gray, tbl[i].g);
    end

    // Asynchronous reset while a word is held in the output register.
    run_cycle(1'b1, 8'h5A, 1'b0);
    run_cycle(1'b1, 8'h6B, 1'b0);
    for (int i = 0; i < 4; i++) run_cycle(1'b0, 8'h00, 1'b0);
    check("midreset_pre_valid", RD_VALID, 1'b1);
    check("midreset_pre_data", RD_DATA, 8'h5A);
    #2;
    R_RST = 1'b0;
    #1;
    check_reset_state("reset_mid");
    model_reset();
    @(posedge R_CLK);
    #1;
    R_RST = 1'b1;

    // Full-depth burst: pointer jumps straight to 8 with all slots written.
    for (int i = 0; i < 8; i++) begin
      mem[i] = 8'h80 + 8'(i);
      q.push_back(8'h80 + 8'(i));
    end
    wp = 8;
    wr_ptr_gray = gray(8);
    got = 0;
    for (int n = 0; n < 14; n++) begin
      run_cycle(1'b0, 8'h00, 1'b1);
      if (RD_VALID) begin
        check("burst_data", RD_DATA, 32'h80 + got);
        got++;
      end
    end
    check("burst_count", got, 8);
    check("burst_empty", EMPTY, 1'b1);
    check("burst_gray", rd_ptr_gray, 4'b1100);

    // 20-word stream crossing the pointer wrap, consumer always ready.
    got = 0; nxt = 0; gaps = 0; primed = 1'b0;
    for (int cyc = 0; cyc < 80 && got < 20; cyc++) begin
      wr = (nxt < 20) && (occupancy() < 8);
      run_cycle(wr, 8'(nxt), 1'b1);
      if (wr) nxt++;
      if (RD_VALID) begin
        check("wrap_data", RD_DATA, got);
        got++;
        primed = 1'b1;
      end else if (primed) begin
        gaps++;
      end
    end
    check("wrap_count", got, 20);
    check("wrap_gaps", gaps, 0);

`ifdef FIFO_RD_LEVEL_EN
    // Level: five words, one pop into the stalled output register.
    model_reset();
    R_RST = 1'b0;
    @(posedge R_CLK);
    #1;
    R_RST = 1'b1;
    for (int i = 0; i < 5; i++) run_cycle(1'b1, 8'(8'h40 + i), 1'b0);
    for (int i = 0; i < 4; i++) run_cycle(1'b0, 8'h00, 1'b0);
    check("level_settled", RD_LEVEL, 4'd4);
    for (int i = 0; i < 4; i++) begin
      run_cycle(1'b0, 8'h00, 1'b1);
      check("level_step", RD_LEVEL, 32'(3 - i));
    end
`endif

    // Randomised traffic against the model.
    for (int n = 0; n < 600; n++) begin
      wr = ($urandom_range(0, 1) == 1) && (occupancy() < 8);
      run_cycle(wr, 8'($urandom), $urandom_range(0, 3) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
